// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: framed serial receiver with start/stop checking and a valid/ready holding register.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] pout,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] shreg_q, pout_q;
  logic valid_q, busy_q, ferr_q, ovr_q;
  logic good, take;
  assign good = (state_q == STOP) && !sin;
  // a full holding register may still take the new word if it is being consumed on this edge
  assign take = !valid_q || out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: if (sin) begin
          state_q <= DATA;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        DATA: begin
          shreg_q <= {sin, shreg_q[WIDTH-1:1]};
          cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
          state_q <= (cnt_q == LAST) ? STOP : DATA;
        end
        STOP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ferr_q  <= sin;
        end
        default: state_q <= IDLE;
      endcase
      if (good && take) begin
        pout_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
      ovr_q <= (good && !take) || (ovr_q && !clr_ovr);
    end
  end
  assign pout      = pout_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: directed vector table, reset-mid-frame sequence and random run against a frame-level model.
module tb_sipo_frame_ctrl;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b0, sin = 1'b0, out_ready = 1'b0, clr_ovr = 1'b0;
  logic [W-1:0] pout;
  logic out_valid, busy, frame_err, overrun;
  int vec = 0, bad = 0;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .out_ready(out_ready), .clr_ovr(clr_ovr),
    .pout(pout), .out_valid(out_valid), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s, r, c, x;
    logic [W-1:0] p;
    logic v, b, e, o;
  } vec_t;
  vec_t tbl[$];

  // model: bits collected in the current frame (0 = idle, 1 = start seen, W+1 = awaiting stop)
  int m_nb = 0;
  logic [W-1:0] m_word = '0, m_pout = '0;
  logic m_valid = 1'b0, m_busy = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  task automatic model(input logic s, r, c, x);
    logic good;
    good = 1'b0;
    if (x) begin
      m_nb = 0; m_word = '0; m_pout = '0;
      m_valid = 1'b0; m_busy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      m_ferr = 1'b0;
      if (m_nb == 0) begin
        if (s) begin m_nb = 1; m_word = '0; end
      end else if (m_nb <= W) begin
        m_word[m_nb-1] = s;
        m_nb++;
      end else begin
        m_ferr = s;
        good = !s;
        m_nb = 0;
      end
      m_ovr = (good && m_valid && !r) || (m_ovr && !c);
      if (good && (!m_valid || r)) begin m_pout = m_word; m_valid = 1'b1; end
      else if (m_valid && r) m_valid = 1'b0;
      m_busy = (m_nb != 0);
    end
  endtask

  task automatic tick(input logic s, r, c, x);
    sin = s; out_ready = r; clr_ovr = c; rst = x;
    @(posedge clk);
    model(s, r, c, x);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [W-1:0] ep, input logic ev, eb, ee, eo);
    vec++;
    if ({pout, out_valid, busy, frame_err, overrun} !== {ep, ev, eb, ee, eo}) begin
      bad++;
      $display("FAIL %s: got pout=%h valid=%b busy=%b ferr=%b ovr=%b, want pout=%h valid=%b busy=%b ferr=%b ovr=%b",
               nm, pout, out_valid, busy, frame_err, overrun, ep, ev, eb, ee, eo);
    end
  endtask

  task automatic add(input logic s, r, c, x, input logic [W-1:0] p, input logic v, b, e, o);
    tbl.push_back('{s, r, c, x, p, v, b, e, o});
  endtask

  initial begin
    add(0,0,0,1, 4'h0,0,0,0,0);
    add(0,0,0,0, 4'h0,0,0,0,0);
    add(1,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0, 4'h0,0,1,0,0);
    add(0,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0, 4'h0,0,1,0,0);
    add(0,0,0,0, 4'hD,1,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,0,0, 4'hD,0,0,0,0);
    add(1,0,0,0, 4'hD,0,1,0,0);
    add(0,0,0,0, 4'hD,0,1,0,0);
    add(1,0,0,0, 4'hD,0,1,0,0);
    add(0,0,0,0, 4'hD,0,1,0,0);
    add(0,0,0,0, 4'hD,0,1,0,0);
    add(1,0,0,0, 4'hD,0,0,1,0);
    add(0,0,0,0, 4'hD,0,0,0,0);
    add(0,0,0,0, 4'hD,0,0,0,0);
    add(1,0,0,0, 4'hD,0,1,0,0);
    add(1,0,0,0, 4'hD,0,1,0,0);
    add(0,0,0,0, 4'hD,0,1,0,0);
    add(1,0,0,0, 4'hD,0,1,0,0);
    add(1,0,0,0, 4'hD,0,1,0,0);
    add(0,0,0,0, 4'hD,1,0,0,0);
    add(1,0,0,0, 4'hD,1,1,0,0);
    add(0,0,0,0, 4'hD,1,1,0,0);
    add(0,0,0,0, 4'hD,1,1,0,0);
    add(1,0,0,0, 4'hD,1,1,0,0);
    add(0,0,0,0, 4'hD,1,1,0,0);
    add(0,0,0,0, 4'hD,1,0,0,1);
    add(0,0,1,0, 4'hD,1,0,0,0);
    add(1,0,0,0, 4'hD,1,1,0,0);
    for (int i = 0; i < 4; i++) add(1,0,0,0, 4'hD,1,1,0,0);
    add(0,1,0,0, 4'hF,1,0,0,0);
    add(1,0,0,0, 4'hF,1,1,0,0);
    add(1,0,0,0, 4'hF,1,1,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0, 4'hF,1,1,0,0);
    add(0,0,1,0, 4'hF,1,0,0,1);
    add(0,0,1,0, 4'hF,1,0,0,0);
    foreach (tbl[i]) begin
      tick(tbl[i].s, tbl[i].r, tbl[i].c, tbl[i].x);
      cmp($sformatf("table[%0d]", i), tbl[i].p, tbl[i].v, tbl[i].b, tbl[i].e, tbl[i].o);
    end
    tick(1,0,0,0); tick(1,0,0,0); tick(0,0,0,0);
    cmp("pre_reset_busy", 4'hF, 1, 1, 0, 0);
    tick(1,0,0,1);
    cmp("mid_frame_reset", 4'h0, 0, 0, 0, 0);
    tick(0,0,0,0);
    cmp("post_reset_idle", 4'h0, 0, 0, 0, 0);
    tick(1,0,0,0); tick(0,0,0,0); tick(1,0,0,0); tick(1,0,0,0); tick(0,0,0,0);
    tick(0,0,0,0);
    cmp("frame_after_reset", 4'h6, 1, 0, 0, 0);
    tick(1,1,0,0);
    cmp("back_to_back_start", 4'h6, 0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic s, r, c, x;
      s = (m_nb == 0) ? ($urandom_range(0, 2) == 0) :
          (m_nb == W + 1) ? ($urandom_range(0, 6) == 0) : 1'($urandom);
      r = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 19) == 0);
      x = ($urandom_range(0, 299) == 0);
      tick(s, r, c, x);
      cmp($sformatf("random[%0d]", i), m_pout, m_valid, m_busy, m_ferr, m_ovr);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
